ecc_dec_pipe: RTL and testbench
===============================

ECC_DEC_PIPE -- requirements
Module: ecc_dec_pipe

Interface
REQ-001 SHALL have parameter MAX_CODEWORD_WIDTH, default 32, meaning widest supported codeword (8, 16 or 32).
REQ-002 SHALL have parameter MAX_INFO_WIDTH, default 26, meaning widest info field (4, 11 or 26, matching MAX_CODEWORD_WIDTH).
REQ-003 SHALL have parameter AMBA_WORD, default 32, meaning width of work_mod.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port in_valid  input  1  codeword present.
REQ-007 SHALL have port in_ready  output  1  block accepts codeword this cycle.
REQ-008 SHALL have port data_in  input  MAX_CODEWORD_WIDTH  received codeword, as produced by ENC.
REQ-009 SHALL have port work_mod  input  AMBA_WORD  mode; only bits [1:0] used, sampled with data_in.
REQ-010 SHALL have port out_valid  output  1  decoded result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port data_out  output  MAX_INFO_WIDTH  corrected info bits, zero-extended.
REQ-013 SHALL have port num_of_errors  output  2  00 none, 01 single corrected, 10 double detected, 11 illegal mode.

Function
REQ-014 Mode SHALL map work_mod[1:0] 00 -> 8-bit codeword/4 info, 01 -> 16/11, 10 -> 32/26, 11 -> illegal.
REQ-015 Mode with codeword width > MAX_CODEWORD_WIDTH SHALL also be illegal.
REQ-016 Codeword layout and parity-check matrix SHALL be bit-identical to ENC, taken from ENC's shared table (info in low K bits, overall parity in bit N-1).
REQ-017 Bits of data_in above active width N SHALL be ignored.
REQ-018 Stage 1 SHALL register Hamming syndrome, overall-parity check, raw codeword and mode.
REQ-019 Stage 2 SHALL register correction result: syndrome 0, parity ok -> 00, data unchanged.
REQ-020 Syndrome 0, parity bad -> 01, data unchanged (overall parity bit flipped).
REQ-021 Syndrome matches a column, parity bad -> 01, that bit inverted before info extraction.
REQ-022 Syndrome nonzero, parity ok, or syndrome matching no column -> 10, data_out = uncorrected info bits.
REQ-023 Illegal mode -> 11, data_out all zeros.
REQ-024 Latency SHALL be 2 cycles from accepted input (in_valid && in_ready) to out_valid, with out_ready high.
REQ-025 Throughput SHALL be one codeword per cycle with out_ready held high.
REQ-026 Each stage SHALL advance when its successor is empty or advancing; in_ready = stage 1 empty or advancing (combinational, no combinational in_valid -> in_ready path).
REQ-027 While out_valid && !out_ready, data_out and num_of_errors SHALL be held stable; no result dropped or duplicated.
REQ-028 Both stages full under backpressure SHALL deassert in_ready; simultaneous out accept and in accept in one cycle SHALL be lossless.
REQ-029 Results SHALL emerge in acceptance order.

Reset
REQ-030 rst high at a clock edge SHALL clear both stage valids; out_valid = 0, data_out = 0, num_of_errors = 00 next cycle.
REQ-031 in_ready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-032 Reset mid-operation SHALL discard all in-flight codewords without emitting them.

Configuration
REQ-033 Macro ECC_DEC_PIPE_STATS_EN, when defined, SHALL add outputs single_cnt and double_cnt (16 bits each, saturating at 16'hFFFF), incremented on each handshaken result of 01 resp. 10, cleared by rst.
REQ-034 Without ECC_DEC_PIPE_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-035 Mode 00, ENC codeword of 4'b1010, out_ready=1 -> out_valid 2 cycles later, data_out 4'b1010, num_of_errors 00.
REQ-036 Same codeword with bit 2 flipped -> data_out 4'b1010, 01; with bits 0 and 5 flipped -> 10; with bit 7 flipped -> 4'b1010, 01.
REQ-037 Mode 10, 26'h2AAAAAA codewords back-to-back with out_ready toggling 1,0,0,1 -> every result delivered once, in order; in_ready low while both stages full.
REQ-038 MAX_CODEWORD_WIDTH=16 instance, work_mod=2'b10 -> num_of_errors 11, data_out 0; work_mod=2'b11 -> same.
REQ-039 rst asserted one cycle after accepting two codewords -> no out_valid ever produced for them; in_ready=1 cycle after release.
REQ-040 With ECC_DEC_PIPE_STATS_EN, 3 single-error and 2 double-error codewords -> single_cnt 3, double_cnt 2; force 16'hFFFF + 1 single -> stays 16'hFFFF.

Source files
------------

// File: rtl/ecc_dec_pipe.sv
`timescale 1ns/1ps
// ecc_dec_pipe -- two-stage pipelined SEC-DED Hamming decoder.
//
// Purpose: accepts a codeword produced by the matching encoder, computes the
// Hamming syndrome and overall parity (stage 1), then corrects a single-bit
// error or flags a double error and extracts the info bits (stage 2).
//
// Codeword layout (N = codeword width, K = info width, R = N-K-1):
//   bits [K-1:0]     info bits; info bit i has check column = i-th integer
//                    >= 3 that is not a power of two (3,5,6,7,9,10,...)
//   bits [K+R-1:K]   Hamming check bits; check bit j has column (1 << j)
//   bit  [N-1]       overall parity, making the whole codeword even
// The column ordering is shared by all modes, so the 8- and 16-bit codes are
// prefixes of the 32-bit code.
//
// Modes (work_mod[1:0]): 00 -> 8/4, 01 -> 16/11, 10 -> 32/26, 11 -> illegal.
// A mode wider than MAX_CODEWORD_WIDTH is also illegal.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake
//   data_in, work_mod     codeword and mode (sampled together)
//   out_valid / out_ready output handshake
//   data_out              corrected info bits, zero-extended
//   num_of_errors         00 none, 01 corrected, 10 double, 11 illegal mode
//   single_cnt, double_cnt  saturating result counters (only when the macro
//                         ECC_DEC_PIPE_STATS_EN is defined)
module ecc_dec_pipe #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int AMBA_WORD          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors
`ifdef ECC_DEC_PIPE_STATS_EN
    ,
    output logic [15:0]                   single_cnt,
    output logic [15:0]                   double_cnt
`endif
);

    localparam int CW = 32;  // widest codeword handled internally
    localparam int KW = 26;  // widest info field
    localparam int RW = 5;   // widest Hamming syndrome

    // Check column of info bit idx: the idx-th non-power-of-two value >= 3.
    function automatic logic [RW-1:0] col_of(input int idx);
        logic [RW-1:0] res;
        int            cnt;
        res = 5'd0;
        cnt = 0;
        for (int c = 3; c < 32; c++) begin
            if ((c & (c - 1)) != 0) begin
                if (cnt == idx) begin
                    res = RW'(c);
                end else begin
                    res = res;
                end
                cnt++;
            end else begin
                cnt = cnt;
            end
        end
        return res;
    endfunction

    function automatic int cw_width(input logic [1:0] m);
        case (m)
            2'b00:   return 8;
            2'b01:   return 16;
            2'b10:   return 32;
            default: return 0;
        endcase
    endfunction

    function automatic int info_width(input logic [1:0] m);
        case (m)
            2'b00:   return 4;
            2'b01:   return 11;
            2'b10:   return 26;
            default: return 0;
        endcase
    endfunction

    function automatic int chk_width(input logic [1:0] m);
        case (m)
            2'b00:   return 3;
            2'b01:   return 4;
            2'b10:   return 5;
            default: return 0;
        endcase
    endfunction

    // Stage 1 registers
    logic          s1_valid;
    logic [RW-1:0] s1_syn;
    logic          s1_par_err;
    logic [CW-1:0] s1_cw;
    logic [1:0]    s1_mode;
    logic          s1_illegal;

    // Stage 1 combinational results
    logic [CW-1:0] cw_act;
    logic [RW-1:0] syn_c;
    logic          par_c;
    logic          illegal_c;

    // Stage 2 combinational results
    logic [KW-1:0] data_c;
    logic [1:0]    err_c;

    logic adv1;
    logic adv2;

    // A stage advances when its successor is empty or advancing.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = !rst && adv1;

    // Stage 1: mask to the active width, compute syndrome and overall parity.
    always_comb begin
        logic [CW-1:0] cw_ext;
        logic [RW-1:0] hi;
        int            n_w;
        int            k_w;
        int            r_w;
        n_w    = cw_width(work_mod[1:0]);
        k_w    = info_width(work_mod[1:0]);
        r_w    = chk_width(work_mod[1:0]);
        cw_ext = '0;
        cw_ext[MAX_CODEWORD_WIDTH-1:0] = data_in;
        for (int i = 0; i < CW; i++) begin
            cw_act[i] = (i < n_w) ? cw_ext[i] : 1'b0;
        end
        syn_c = 5'd0;
        for (int i = 0; i < KW; i++) begin
            if ((i < k_w) && cw_act[i]) begin
                syn_c = syn_c ^ col_of(i);
            end else begin
                syn_c = syn_c;
            end
        end
        // Check bits sit directly above the info field.
        hi = RW'(cw_act >> k_w);
        for (int j = 0; j < RW; j++) begin
            if (j < r_w) begin
                syn_c[j] = syn_c[j] ^ hi[j];
            end else begin
                syn_c[j] = syn_c[j];
            end
        end
        par_c     = ^cw_act;
        illegal_c = (n_w == 0) || (n_w > MAX_CODEWORD_WIDTH);
    end

    // Stage 2: classify the syndrome and correct the info field.
    always_comb begin
        int   k2;
        logic found;
        k2    = info_width(s1_mode);
        found = 1'b0;
        for (int i = 0; i < KW; i++) begin
            data_c[i] = (i < k2) ? s1_cw[i] : 1'b0;
        end
        if (s1_illegal) begin
            err_c  = 2'b11;
            data_c = '0;
        end else if (s1_syn == 5'd0) begin
            // Clean, or only the overall parity bit flipped.
            err_c = s1_par_err ? 2'b01 : 2'b00;
        end else if (!s1_par_err) begin
            err_c = 2'b10;
        end else if ((s1_syn & (s1_syn - 5'd1)) == 5'd0) begin
            // Single error in a check bit: info field already correct.
            err_c = 2'b01;
        end else begin
            for (int i = 0; i < KW; i++) begin
                if ((i < k2) && (col_of(i) == s1_syn)) begin
                    data_c[i] = ~data_c[i];
                    found     = 1'b1;
                end else begin
                    data_c[i] = data_c[i];
                end
            end
            err_c = found ? 2'b01 : 2'b10;
        end
    end

    // Pipeline registers for both stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_syn        <= 5'd0;
            s1_par_err    <= 1'b0;
            s1_cw         <= 32'd0;
            s1_mode       <= 2'b00;
            s1_illegal    <= 1'b0;
            out_valid     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= 2'b00;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_syn     <= syn_c;
                    s1_par_err <= par_c;
                    s1_cw      <= cw_act;
                    s1_mode    <= work_mod[1:0];
                    s1_illegal <= illegal_c;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    data_out      <= data_c[MAX_INFO_WIDTH-1:0];
                    num_of_errors <= err_c;
                end
            end
        end
    end

`ifdef ECC_DEC_PIPE_STATS_EN
    // Saturating counters of delivered corrected / double-error results.
    always_ff @(posedge clk) begin
        if (rst) begin
            single_cnt <= 16'd0;
            double_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            if ((num_of_errors == 2'b01) && (single_cnt != 16'hFFFF)) begin
                single_cnt <= single_cnt + 16'd1;
            end
            if ((num_of_errors == 2'b10) && (double_cnt != 16'hFFFF)) begin
                double_cnt <= double_cnt + 16'd1;
            end
        end
    end
`endif

    // Mode bits above [1:0], raw bits above the info field and info bits
    // beyond MAX_INFO_WIDTH carry no meaning for the result.
    logic unused_bits;
    assign unused_bits = ^{work_mod[AMBA_WORD-1:2], s1_cw[CW-1:KW], data_c};

endmodule

// File: tb/tb_ecc_dec_pipe.sv
`timescale 1ns/1ps
// Testbench for ecc_dec_pipe: directed codewords with hand-computed results,
// scoreboard queues filled on acceptance and drained by output monitors.
module tb_ecc_dec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // Default instance (32-bit codewords)
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = 32'd0;
    logic [31:0] work_mod = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [25:0] data_out;
    logic [1:0]  num_of_errors;

    // Narrow instance (16-bit codewords)
    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] data_in16 = 16'd0;
    logic [31:0] work_mod16 = 32'd0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [10:0] data_out16;
    logic [1:0]  num_of_errors16;

`ifdef ECC_DEC_PIPE_STATS_EN
    logic [15:0] single_cnt, double_cnt, single_cnt16, double_cnt16;
`endif

    ecc_dec_pipe u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .work_mod(work_mod), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .num_of_errors(num_of_errors)
`ifdef ECC_DEC_PIPE_STATS_EN
        , .single_cnt(single_cnt), .double_cnt(double_cnt)
`endif
    );

    ecc_dec_pipe #(.MAX_CODEWORD_WIDTH(16), .MAX_INFO_WIDTH(11), .AMBA_WORD(32)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .data_in(data_in16), .work_mod(work_mod16), .out_valid(out_valid16),
        .out_ready(out_ready16), .data_out(data_out16), .num_of_errors(num_of_errors16)
`ifdef ECC_DEC_PIPE_STATS_EN
        , .single_cnt(single_cnt16), .double_cnt(double_cnt16)
`endif
    );

    typedef struct packed {
        logic [25:0] data;
        logic [1:0]  err;
    } exp_t;

    exp_t q0[$];
    exp_t q16[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for u0: checks popped results and stability while stalled.
    logic        stalled = 1'b0;
    logic [25:0] held_data = 26'd0;
    logic [1:0]  held_err = 2'b00;
    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {6'd0, data_out}, {6'd0, held_data});
                chk("hold_err", {30'd0, num_of_errors}, {30'd0, held_err});
            end
            stalled   <= out_valid && !out_ready;
            held_data <= data_out;
            held_err  <= num_of_errors;
            if (out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got data 0x%0h err %0d, expected no output",
                             data_out, num_of_errors);
                end else begin
                    chk("data_out", {6'd0, data_out}, {6'd0, q0[0].data});
                    chk("num_of_errors", {30'd0, num_of_errors}, {30'd0, q0[0].err});
                    void'(q0.pop_front());
                end
            end
        end
    end

    // Monitor for u16.
    always @(negedge clk) begin
        if (!rst && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output16: got data 0x%0h err %0d, expected no output",
                         data_out16, num_of_errors16);
            end else begin
                chk("data_out16", {21'd0, data_out16}, {6'd0, q16[0].data});
                chk("num_of_errors16", {30'd0, num_of_errors16}, {30'd0, q16[0].err});
                void'(q16.pop_front());
            end
        end
    end

    // Present one codeword to u0 until accepted; called and returns at posedge+1.
    task automatic send0(input logic [31:0] cw, input logic [1:0] m,
                         input logic [25:0] ed, input logic [1:0] ee);
        int b;
        b = 0;
        in_valid = 1'b1;
        data_in  = cw;
        work_mod = {30'd0, m};
        @(negedge clk);
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (in_ready) begin
            q0.push_back({ed, ee});
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] cw, input logic [1:0] m,
                          input logic [25:0] ed, input logic [1:0] ee);
        int b;
        b = 0;
        in_valid16 = 1'b1;
        data_in16  = cw;
        work_mod16 = {30'd0, m};
        @(negedge clk);
        while (!in_ready16 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (in_ready16) begin
            q16.push_back({ed, ee});
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout16: in_ready16 got 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
    endtask

    // Wait for both scoreboards to empty, bounded.
    task automatic drain();
        int b;
        b = 0;
        while ((q0.size() != 0 || q16.size() != 0) && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q16", q16.size(), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        q0.delete();
        q16.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ghost;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", {6'd0, data_out}, 32'd0);
        chk("rst_num_err", {30'd0, num_of_errors}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Latency: 4'b1010 encodes to 8'hAA in mode 00
        out_ready = 1'b1;
        send0(32'h0000_00AA, 2'b00, 26'hA, 2'b00);
        @(negedge clk);
        chk("latency_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_c2", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        send0(32'h0000_00AE, 2'b00, 26'hA, 2'b01);        // bit 2 flipped
        send0(32'h0000_008B, 2'b00, 26'hB, 2'b10);        // bits 0,5 flipped
        send0(32'h0000_002A, 2'b00, 26'hA, 2'b01);        // overall parity flipped
        send0(32'hFFFF_FFAA, 2'b00, 26'hA, 2'b00);        // bits above N ignored
        send0(32'h0000_0000, 2'b01, 26'h0, 2'b00);
        send0(32'h0000_9801, 2'b01, 26'h1, 2'b00);        // info 11'h001
        send0(32'h0000_9811, 2'b01, 26'h1, 2'b01);        // info bit 4 flipped
        send0(32'hAAAA_AAAA, 2'b10, 26'h2AAAAAA, 2'b00);
        send0(32'hAAAA_AAAB, 2'b10, 26'h2AAAAAA, 2'b01);  // bit 0 flipped
        send0(32'hAAAA_AAA9, 2'b10, 26'h2AAAAA9, 2'b10);  // bits 0,1 flipped
        send0(32'hA2AA_AAAA, 2'b10, 26'h2AAAAAA, 2'b01);  // check bit 27 flipped
        send0(32'h0000_0003, 2'b11, 26'h0, 2'b11);        // illegal mode
        drain();

        // Backpressure: fill both stages, then toggle out_ready 1,0,0,1
        out_ready = 1'b0;
        send0(32'hAAAA_AAAA, 2'b10, 26'h2AAAAAA, 2'b00);
        send0(32'hAAAA_AAAB, 2'b10, 26'h2AAAAAA, 2'b01);
        in_valid = 1'b1;
        data_in  = 32'hAAAA_AAA9;
        work_mod = 32'd2;
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        fork
            send0(32'hAAAA_AAA9, 2'b10, 26'h2AAAAA9, 2'b10);
            begin
                out_ready = 1'b1;
                @(posedge clk); #1; out_ready = 1'b0;
                @(posedge clk); #1; out_ready = 1'b0;
                @(posedge clk); #1; out_ready = 1'b1;
            end
        join
        send0(32'h0000_9801, 2'b01, 26'h1, 2'b00);
        drain();

        // Reset with two codewords in flight
        out_ready = 1'b0;
        send0(32'h0000_00AA, 2'b00, 26'hA, 2'b00);
        send0(32'h0000_00AE, 2'b00, 26'hA, 2'b01);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
        ghost = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) ghost++;
            @(negedge clk);
        end
        chk("midrst_no_output", ghost, 32'd0);
        @(posedge clk);
        #1;
        send0(32'h0000_00AE, 2'b00, 26'hA, 2'b01);
        drain();

        // 16-bit instance: modes too wide or illegal
        send16(16'h0000, 2'b10, 26'h0, 2'b11);
        send16(16'hFFFF, 2'b11, 26'h0, 2'b11);
        send16(16'h9801, 2'b01, 26'h1, 2'b00);
        drain();

`ifdef ECC_DEC_PIPE_STATS_EN
        do_reset();
        out_ready = 1'b1;
        send0(32'h0000_00AE, 2'b00, 26'hA, 2'b01);
        send0(32'hAAAA_AAAB, 2'b10, 26'h2AAAAAA, 2'b01);
        send0(32'h0000_9811, 2'b01, 26'h1, 2'b01);
        send0(32'h0000_008B, 2'b00, 26'hB, 2'b10);
        send0(32'hAAAA_AAA9, 2'b10, 26'h2AAAAA9, 2'b10);
        drain();
        chk("single_cnt", {16'd0, single_cnt}, 32'd3);
        chk("double_cnt", {16'd0, double_cnt}, 32'd2);
        force u0.single_cnt = 16'hFFFF;
        @(negedge clk);
        release u0.single_cnt;
        @(posedge clk);
        #1;
        send0(32'h0000_002A, 2'b00, 26'hA, 2'b01);
        drain();
        chk("single_cnt_sat", {16'd0, single_cnt}, 32'h0000_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
